// File: rtl/vector_buffer.sv
// Serial-to-parallel collector: MSB-first bit assembly into WIDTH-bit words, queued in a DEPTH-entry FIFO.
// Define VECTOR_BUFFER_OVF_EN to add the sticky overflow output for dropped words.
module vector_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             input_bit,
  input  logic             bit_valid,
  input  logic             req,
  output logic [WIDTH-1:0] vector,
  output logic             valid
`ifdef VECTOR_BUFFER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] vec_q;
  logic             vld_q;
  logic             word_done, push, pop;

  assign word_done = bit_valid && (cnt_q == LAST_BIT);
  assign pop       = req && (count_q != '0);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the word.
  assign push      = word_done && ((count_q != FULL_CNT) || pop);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (bit_valid) begin
      shift_d = {shift_q[WIDTH-2:0], input_bit};
      cnt_d   = word_done ? '0 : cnt_q + 1'b1;
    end
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vec_q   <= '0;
      vld_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      vld_q   <= pop;
      if (push) begin
        mem_q[wptr_q] <= shift_d;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        vec_q  <= mem_q[rptr_q];
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  assign vector = vec_q;
  assign valid  = vld_q;

`ifdef VECTOR_BUFFER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_q | (word_done && !push);
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_vector_buffer.sv
// Bench for vector_buffer: directed scenarios plus random traffic against a queue-based reference model.
module tb_vector_buffer;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         input_bit = 1'b0;
  logic         bit_valid = 1'b0;
  logic         req = 1'b0;
  logic [W-1:0] vector;
  logic         valid;
`ifdef VECTOR_BUFFER_OVF_EN
  logic         overflow;
`endif

  vector_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .input_bit(input_bit), .bit_valid(bit_valid),
    .req(req), .vector(vector), .valid(valid)
`ifdef VECTOR_BUFFER_OVF_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_acc;
  int           m_nbits;
  logic [W-1:0] m_vec;
  logic         m_vld;
  logic         m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_acc = '0; m_nbits = 0; m_vec = '0; m_vld = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bit_valid = 1'b0; req = 1'b0;
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_vector", {24'd0, vector}, 32'd0);
`ifdef VECTOR_BUFFER_OVF_EN
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // one clock: drive at negedge, update model and compare after the rising edge
  task automatic step(input logic b, input logic bv, input logic rq);
    @(negedge clk);
    input_bit = b; bit_valid = bv; req = rq;
    @(posedge clk);
    #1;
    m_vld = 1'b0;
    if (rq && m_q.size() > 0) begin
      m_vec = m_q.pop_front();
      m_vld = 1'b1;
    end
    if (bv) begin
      m_acc = (m_acc << 1) | W'(b);
      m_nbits++;
      if (m_nbits == W) begin
        m_nbits = 0;
        if (m_q.size() < D) m_q.push_back(m_acc);
        else m_ovf = 1'b1;
      end
    end
    chk("valid", {31'd0, valid}, {31'd0, m_vld});
    chk("vector", {24'd0, vector}, {24'd0, m_vec});
`ifdef VECTOR_BUFFER_OVF_EN
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`endif
  endtask

  task automatic feed_word(input logic [W-1:0] w, input logic rq_last, input bit gaps);
    for (int i = W - 1; i >= 0; i--) begin
      step(w[i], 1'b1, (i == 0) ? rq_last : 1'b0);
      if (gaps) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pop_expect(input string tag, input logic [W-1:0] exp);
    step(1'b0, 1'b0, 1'b1);
    chk({tag, "_v"}, {31'd0, valid}, 32'd1);
    chk(tag, {24'd0, vector}, {24'd0, exp});
  endtask

  initial begin
    model_clear();
    do_reset();

    // reset mid-assembly discards the partial word
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    do_reset();
    feed_word(8'b10110011, 1'b0, 1'b0);
    pop_expect("rst_mid", 8'hB3);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_mid_pulse", {31'd0, valid}, 32'd0);

    // ordering with req held
    feed_word(8'h01, 1'b0, 1'b0);
    feed_word(8'h02, 1'b0, 1'b0);
    feed_word(8'h03, 1'b0, 1'b0);
    pop_expect("ord0", 8'h01);
    pop_expect("ord1", 8'h02);
    pop_expect("ord2", 8'h03);
    step(1'b0, 1'b0, 1'b1);
    chk("ord_empty_v", {31'd0, valid}, 32'd0);
    chk("ord_hold", {24'd0, vector}, 32'h03);

    // fill past capacity: A4 and A5 dropped
    for (int k = 0; k < 6; k++) begin
      feed_word(8'hA0 + 8'(k), 1'b0, 1'b0);
`ifdef VECTOR_BUFFER_OVF_EN
      if (k == 3) chk("ovf_before", {31'd0, overflow}, 32'd0);
      if (k == 4) chk("ovf_after", {31'd0, overflow}, 32'd1);
`endif
    end
    for (int k = 0; k < 4; k++) pop_expect("fill", 8'hA0 + 8'(k));
    step(1'b0, 1'b0, 1'b1);
    chk("fill_empty", {31'd0, valid}, 32'd0);

    // simultaneous push and pop on a full FIFO
    do_reset();
    for (int k = 0; k < 4; k++) feed_word(8'hC0 + 8'(k), 1'b0, 1'b0);
    feed_word(8'hC4, 1'b1, 1'b0);
    chk("sim_pop", {24'd0, vector}, 32'hC0);
`ifdef VECTOR_BUFFER_OVF_EN
    chk("sim_ovf", {31'd0, overflow}, 32'd0);
`endif
    for (int k = 1; k < 5; k++) pop_expect("sim", 8'hC0 + 8'(k));
    step(1'b0, 1'b0, 1'b1);
    chk("sim_empty", {31'd0, valid}, 32'd0);

    // bit_valid gaps
    feed_word(8'h5A, 1'b0, 1'b1);
    feed_word(8'hE7, 1'b0, 1'b1);
    pop_expect("gap0", 8'h5A);
    pop_expect("gap1", 8'hE7);
    step(1'b0, 1'b0, 1'b1);
    chk("gap_empty", {31'd0, valid}, 32'd0);

    // random stream then drain
    do_reset();
    for (int i = 0; i < 100; i++) step(1'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1);

    // fully random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 2));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
